// File: rtl/bresenham_span_fill.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bresenham_span_fill : one-pixel-per-clock horizontal span writer + frame RAM
// Revision 1.0
// ---------------------------------------------------------------------------

module simple_ram_dual_clock (
  input  logic [7:0]  data,
  input  logic [15:0] read_addr,
  input  logic [15:0] write_addr,
  input  logic        we,
  input  logic        read_clock,
  input  logic        write_clock,
  output logic [7:0]  q
);
  logic [7:0] mem [0:65535];

  always_ff @(posedge write_clock) begin
    if (we) mem[write_addr] <= data;
  end

  // Same-edge read samples the array before the write lands: old data wins.
  always_ff @(posedge read_clock) begin
    q <= mem[read_addr];
  end
endmodule

module bresenham_span_fill (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_2,
  output logic        ack_2,
  input  logic [7:0]  point_out_a_x,
  input  logic [15:0] point_out_b_xy,
  input  logic [23:0] rgb,
  output logic [7:0]  rdata,
  output logic [7:0]  gdata,
  output logic [7:0]  bdata,
  output logic [15:0] waddr,
  output logic        we
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  x_q;
  logic [7:0]  x_hi_q;
  logic [7:0]  y_q;
  logic [23:0] col_q;

  logic [7:0]  b_x;
  logic [7:0]  x_lo_d;
  logic [7:0]  x_hi_d;

  assign b_x    = point_out_b_xy[15:8];
  assign x_lo_d = (point_out_a_x < b_x) ? point_out_a_x : b_x;
  assign x_hi_d = (point_out_a_x < b_x) ? b_x : point_out_a_x;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= 8'd0;
      x_hi_q  <= 8'd0;
      y_q     <= 8'd0;
      col_q   <= 24'd0;
      we      <= 1'b0;
      ack_2   <= 1'b0;
      waddr   <= 16'd0;
      rdata   <= 8'd0;
      gdata   <= 8'd0;
      bdata   <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          we    <= 1'b0;
          ack_2 <= 1'b0;
          if (req_2) begin
            x_q     <= x_lo_d;
            x_hi_q  <= x_hi_d;
            y_q     <= point_out_b_xy[7:0];
            col_q   <= rgb;
            state_q <= FILL;
          end
        end
        FILL: begin
          we    <= 1'b1;
          waddr <= {y_q, x_q};
          rdata <= col_q[23:16];
          gdata <= col_q[15:8];
          bdata <= col_q[7:0];
          // Compare before incrementing so x_hi = 255 ends without wrapping.
          if (x_q == x_hi_q) begin
            state_q <= DONE;
          end else begin
            x_q <= x_q + 8'd1;
          end
        end
        DONE: begin
          we      <= 1'b0;
          ack_2   <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          we      <= 1'b0;
          ack_2   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_bresenham_span_fill.sv
`default_nettype none
// Testbench for bresenham_span_fill: directed and random spans against a
// pixel-list model, with frame RAM read-back.
module tb_bresenham_span_fill;
  logic        clk;
  logic        rst;
  logic        req_2;
  logic        ack_2;
  logic [7:0]  a_x;
  logic [15:0] b_xy;
  logic [23:0] rgb;
  logic [7:0]  rdata, gdata, bdata;
  logic [15:0] waddr;
  logic        we;
  logic [15:0] rd_addr;
  logic [7:0]  rq, gq, bq;

  int checks = 0;
  int errors = 0;
  logic [23:0] mdl [int];

  bresenham_span_fill dut (
    .clk           (clk),
    .rst           (rst),
    .req_2         (req_2),
    .ack_2         (ack_2),
    .point_out_a_x (a_x),
    .point_out_b_xy(b_xy),
    .rgb           (rgb),
    .rdata         (rdata),
    .gdata         (gdata),
    .bdata         (bdata),
    .waddr         (waddr),
    .we            (we)
  );

  simple_ram_dual_clock ram_r (.data(rdata), .read_addr(rd_addr), .write_addr(waddr),
                               .we(we), .read_clock(clk), .write_clock(clk), .q(rq));
  simple_ram_dual_clock ram_g (.data(gdata), .read_addr(rd_addr), .write_addr(waddr),
                               .we(we), .read_clock(clk), .write_clock(clk), .q(gq));
  simple_ram_dual_clock ram_b (.data(bdata), .read_addr(rd_addr), .write_addr(waddr),
                               .we(we), .read_clock(clk), .write_clock(clk), .q(bq));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"},    32'(we),    32'd0);
    chk({tag, "_ack"},   32'(ack_2), 32'd0);
    chk({tag, "_waddr"}, 32'(waddr), 32'd0);
    chk({tag, "_rgb"},   {8'h0, rdata, gdata, bdata}, 32'd0);
  endtask

  // One span: expected writes are every x from min to max on row y, ascending.
  task automatic do_span(input logic [7:0] ax, input logic [15:0] bxy,
                         input logic [23:0] col, input int busy_at);
    int lo, hi;
    logic [15:0] ea;
    lo = (ax < bxy[15:8]) ? int'(ax) : int'(bxy[15:8]);
    hi = (ax < bxy[15:8]) ? int'(bxy[15:8]) : int'(ax);
    ea = 16'd0;
    a_x = ax; b_xy = bxy; rgb = col; req_2 = 1'b1;
    step();
    req_2 = 1'b0;
    chk("accept_we",  32'(we),    32'd0);
    chk("accept_ack", 32'(ack_2), 32'd0);
    a_x = 8'($urandom); b_xy = 16'($urandom); rgb = 24'($urandom);
    for (int x = lo; x <= hi; x++) begin
      step();
      req_2 = 1'b0;
      ea = {bxy[7:0], 8'(x)};
      chk("fill_we",   32'(we),    32'd1);
      chk("fill_ack",  32'(ack_2), 32'd0);
      chk("fill_addr", 32'(waddr), 32'(ea));
      chk("fill_rgb",  {8'h0, rdata, gdata, bdata}, {8'h0, col});
      if (x - lo == busy_at) req_2 = 1'b1;
      mdl[int'(ea)] = col;
    end
    step();
    req_2 = 1'b0;
    chk("done_ack",   32'(ack_2), 32'd1);
    chk("done_we",    32'(we),    32'd0);
    chk("done_waddr", 32'(waddr), 32'(ea));
    chk("done_rgb",   {8'h0, rdata, gdata, bdata}, {8'h0, col});
  endtask

  task automatic rd(input logic [15:0] addr);
    rd_addr = addr;
    step();
    chk("readback", {8'h0, rq, gq, bq}, {8'h0, mdl[int'(addr)]});
  endtask

  initial begin
    logic [7:0] rx, rb, ry;
    logic [23:0] rc;
    rst = 1'b1; req_2 = 1'b0; a_x = 8'h0; b_xy = 16'h0; rgb = 24'h0; rd_addr = 16'h0;
    step();
    chk_zero("reset");
    rst = 1'b0;
    step();

    // Pre-load 0x0003 so the basic fill can be shown to leave it alone.
    do_span(8'h03, 16'h0300, 24'h112233, -1);
    step();
    do_span(8'h00, 16'h0200, 24'hAABBCC, -1);
    step();
    rd(16'h0000); rd(16'h0001); rd(16'h0002); rd(16'h0003);

    do_span(8'h10, 16'h0C05, 24'h123456, -1);
    step();
    do_span(8'h07, 16'h0709, 24'h0F0E0D, -1);
    step();
    do_span(8'hFE, 16'hFFFF, 24'h778899, -1);
    step();
    chk("nowrap_we", 32'(we), 32'd0);
    rd(16'h050C); rd(16'h0510); rd(16'h0907); rd(16'hFFFE); rd(16'hFFFF);

    // Busy pulse mid-fill, then a request in the ack cycle (back-to-back).
    do_span(8'h48, 16'h4012, 24'hC0FFEE, 2);
    do_span(8'h50, 16'h5113, 24'h5A5A5A, -1);
    step();

    // Reset on the 2nd pixel of a 10-pixel span.
    a_x = 8'h20; b_xy = 16'h2933; rgb = 24'hDEAD01; req_2 = 1'b1;
    step();
    req_2 = 1'b0;
    step();
    chk("rstmid_p1", 32'(waddr), 32'h3320);
    step();
    chk("rstmid_p2", 32'(waddr), 32'h3321);
    rst = 1'b1;
    mdl[32'h3320] = 24'hDEAD01;
    mdl[32'h3321] = 24'hDEAD01;
    step();
    chk_zero("rstmid");
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("rstmid_noack", 32'({ack_2, we}), 32'd0);
    end
    rd(16'h3320); rd(16'h3321);

    // Reset and request on the same edge: request dropped.
    a_x = 8'h01; b_xy = 16'h0401; rgb = 24'h010203; rst = 1'b1; req_2 = 1'b1;
    step();
    rst = 1'b0; req_2 = 1'b0;
    chk_zero("rstreq");
    step();
    chk("rstreq_we", 32'(we), 32'd0);
    step();
    chk("rstreq_we2", 32'(we), 32'd0);

    // RAM collision: read 0x0001 in the same edge it is rewritten.
    rd_addr = 16'h0001;
    a_x = 8'h01; b_xy = 16'h0100; rgb = 24'h445566; req_2 = 1'b1;
    step();
    req_2 = 1'b0;
    step();
    chk("coll_we",   32'(we),    32'd1);
    chk("coll_addr", 32'(waddr), 32'h0001);
    step();
    chk("coll_ack", 32'(ack_2), 32'd1);
    chk("coll_old", {8'h0, rq, gq, bq}, 32'h00AABBCC);
    step();
    chk("coll_new", {8'h0, rq, gq, bq}, 32'h00445566);
    mdl[32'h0001] = 24'h445566;

    // Random spans.
    for (int it = 0; it < 16; it++) begin
      rx = 8'($urandom_range(0, 255));
      rb = (it % 5 == 0) ? rx : 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      rc = 24'($urandom);
      do_span(rx, {rb, ry}, rc, (it % 3 == 0) ? 0 : -1);
      step();
      rd({ry, rx});
      rd({ry, rb});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/bresenham_span_fill.md
# bresenham_span_fill

Horizontal span-fill engine for the Z-buffer rasterizer, paired with three `simple_ram_dual_clock` colour planes (R, G, B) as frame memory. On a request it latches two edge points on the same scan line, a start x and an end (x, y), plus a 24-bit colour. It then writes that colour to every pixel of the inclusive span, one pixel per clock, and acknowledges completion. It sits downstream of the Bresenham edge walker and upstream of the frame RAMs.

## Interface
- Parameters: none. Geometry is fixed at 256×256, addresses are 16 bits, and each plane is 8 bits.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req_2`  input  1  start request, sampled only in IDLE.
- `ack_2`  output  1  one-cycle done pulse.
- `point_out_a_x`  input  8  x of the span start point.
- `point_out_b_xy`  input  16  end point: [15:8] = x, [7:0] = y (the row).
- `rgb`  input  24  fill colour: [23:16] = R, [15:8] = G, [7:0] = B.
- `rdata`, `gdata`, `bdata`  output  8 each  write data to the R, G and B planes.
- `waddr`  output  16  write address, {y, x}.
- `we`  output  1  write enable, shared by all three planes.

## Operation
- The FSM has three states: IDLE, FILL and DONE. All outputs are registered.
- **IDLE.** When `req_2` = 1, the block latches:
  - `x_lo` = min(a_x, b_x) and `x_hi` = max(a_x, b_x);
  - `y` = b_y;
  - the colour.
  
  It sets the x counter to `x_lo` and moves to FILL.
- `req_2` while in FILL or DONE is ignored and is not queued. Inputs may change freely after the latch cycle.
- **FILL**, each cycle:
  - `we` = 1, `waddr` = {y, x};
  - `rdata`/`gdata`/`bdata` = latched R/G/B.
  
  If x == `x_hi`, go to DONE; otherwise x = x + 1.
- The comparison happens before the increment, so `x_hi` = 255 terminates without wrapping.
- **DONE.** `we` = 0, `ack_2` = 1 for exactly one cycle, then return to IDLE.
- Pixel count is |b_x − a_x| + 1. When a_x == b_x, exactly one pixel is written. Reversed order (a_x > b_x) produces the same writes as the swapped case.
- Colour outputs hold their last value when `we` = 0. `waddr` holds its last value.
- **Frame RAM contract** (`simple_ram_dual_clock`, one instance per plane):
  - 65536 × 8 memory with separate read/write clock ports, tied to the same `clk` here;
  - synchronous write of `data` to `write_addr` when `we` = 1;
  - registered read, `q` = mem[`read_addr`] one cycle after the address is applied;
  - the read returns the old data on a same-address collision;
  - no reset of contents; no reset port.

## Timing
- Reset values: `we` = 0, `ack_2` = 0, `waddr` = 0, `rdata`/`gdata`/`bdata` = 0, state = IDLE, counters = 0.
- `req_2` sampled high at edge k gives `we` = 1 with the first pixel from edge k+1. The last pixel is presented at edge k+N, where N = pixel count.
- `ack_2` is high from edge k+N+1 for one cycle, and `we` = 0 in that cycle. A new `req_2` is accepted from edge k+N+2.
- `rst` asserted mid-FILL: at the next edge the fill aborts, `we` = 0, no `ack_2` is issued, and outputs return to reset values.
- `rst` and `req_2` at the same edge: reset wins and the request is dropped.
- Read-back latency from the RAMs is one cycle.

## Test plan
- **Basic fill.** Reset, then a_x = 0x00, b_xy = 0x0200, rgb = 0xAABBCC, one-cycle `req_2`. Required:
  - writes at `waddr` 0x0000, 0x0001, 0x0002, with R/G/B = AA/BB/CC;
  - `ack_2` is one pulse, exactly 3 `we` cycles;
  - reading addresses 0–2 returns AA/BB/CC one cycle later;
  - address 0x0003 is untouched.
- **Reversed order.** a_x = 0x10, b_xy = 0x0C05 → writes 0x050C..0x0510 ascending (5 pixels), then `ack_2`.
- **Single pixel and edge of range.**
  - a_x = b_x = 0x07, y = 0x09 → a single write at 0x0907.
  - a_x = 0xFE, b_xy = 0xFFFF → writes 0xFFFE and 0xFFFF only (no wrap to 0xFF00), then `ack_2`.
- **Busy request and back-to-back.** Pulse `req_2` during a fill → ignored, and the span still completes as latched. Issue a new `req_2` in the cycle after `ack_2` → accepted.
- **Reset mid-fill.** Assert `rst` on the 2nd pixel of a 10-pixel span → `we` = 0 on the next edge, no `ack_2`, all outputs return to zero.
- **RAM collision.** Read an address in the same cycle it is written → the old value is returned; the new value is returned on the next read.
